spike_demux: RTL and testbench

- Output-side counterpart of the time-multiplexed column.
- Each gamma cycle the column is shared by two networks in two half-cycle slots: slot 0 carries network 1, slot 1 carries network 2.
- The block timestamps the first spike per output line in each slot and replays both networks' spikes on separate buses, in real time, during the next gamma cycle.
- Sits between column output_spikes and the multiplexed column's output_spikes1/output_spikes2.

---
 rtl/mux_col_pkg.sv | 20 ++
 rtl/spike_demux_if.sv | 29 ++
 rtl/spike_time_capture.sv | 46 ++++
 rtl/spike_demux.sv | 157 +++++++++++++++
 tb/tb_spike_demux.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_col_pkg.sv
// Shared types and helpers for the time-multiplexed column output demux.
package mux_col_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        FILL,
        RUN
    } demux_state_e;

    // Network carried by each half-cycle slot: slot 0 -> NET1, slot 1 -> NET2.
    typedef enum logic {
        NET1,
        NET2
    } net_id_e;

    function automatic int slot_len(int gamma);
        return gamma / 2;
    endfunction

endpackage

// File: rtl/spike_demux_if.sv
// Spike bus between the shared column and the demux: gamma sync, multiplexed
// column spikes in, one demultiplexed spike bus per network out.
interface spike_demux_if #(
    parameter int Q = 2
);
    logic         grst;
    logic [Q-1:0] col_spikes;
    logic [Q-1:0] output_spikes1;
    logic [Q-1:0] output_spikes2;
    logic         sync_locked;

    // Column / sync source side.
    modport master (
        output grst,
        output col_spikes,
        input  output_spikes1,
        input  output_spikes2,
        input  sync_locked
    );

    // Demux side.
    modport slave (
        input  grst,
        input  col_spikes,
        output output_spikes1,
        output output_spikes2,
        output sync_locked
    );
endinterface

// File: rtl/spike_time_capture.sv
// One slot bank: per-line valid bit plus first-spike timestamp. A clear and a
// capture in the same cycle leave the line holding the new capture.
module spike_time_capture #(
    parameter int Q  = 2,
    parameter int TW = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  clear,
    input  logic                  cap_en,
    input  logic [Q-1:0]          spikes,
    input  logic [TW-1:0]         t,
    output logic [Q-1:0]          valid,
    output logic [Q-1:0][TW-1:0]  stamps
);

    logic [Q-1:0]         valid_q;
    logic [Q-1:0]         valid_live;
    logic [Q-1:0]         wr;
    logic [Q-1:0][TW-1:0] stamps_q;

    // Clear first, then accept only the first spike per line.
    always_comb begin
        valid_live = clear ? '0 : valid_q;
        wr         = {Q{cap_en}} & spikes & ~valid_live;
    end

    // Valid bits and timestamps.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            valid_q  <= '0;
            stamps_q <= '0;
        end else begin
            valid_q <= valid_live | wr;
            for (int q = 0; q < Q; q++) begin
                if (wr[q]) begin
                    stamps_q[q] <= t;
                end
            end
        end
    end

    assign valid  = valid_q;
    assign stamps = stamps_q;

endmodule

// File: rtl/spike_demux.sv
// Output-side demux of the time-multiplexed column. Each gamma cycle the first
// spike per line in each half-cycle slot is timestamped; during the following
// gamma cycle both networks are replayed on separate buses in real time.
// Two ping-pong bank sets (each holding slot 0 and slot 1) alternate between
// capture and replay. The swap takes effect in the cycle where the counter is
// 0, so that cycle already captures into the fresh bank and replays t=0.
// Optional build macro SPIKE_HOLD_EN: a fired line stays high until the end of
// its gamma cycle instead of pulsing for one clk.
module spike_demux
    import mux_col_pkg::*;
#(
    parameter int Q                  = 2,
    parameter int GAMMA_CYCLE_LENGTH = 18
) (
    input logic          clk,
    input logic          rstb,
    spike_demux_if.slave bus
);

    localparam int SLOT_LEN = slot_len(GAMMA_CYCLE_LENGTH);
    localparam int CW       = $clog2(GAMMA_CYCLE_LENGTH);
    localparam int TW       = $clog2(SLOT_LEN);
    localparam logic [CW-1:0] LAST       = CW'(GAMMA_CYCLE_LENGTH - 1);
    localparam logic [CW-1:0] SLOT_START = CW'(SLOT_LEN);

    demux_state_e  state_q;
    logic [CW-1:0] counter_q;
    logic [CW-1:0] counter_next;
    logic          grst_q;
    logic          swap_q;
    logic          sel_q;
    logic          locked_q;

    logic          gamma_start;
    logic          evt;
    logic          cap_bank;
    logic          rep_bank;
    logic          capture_on;
    logic          replay_on;
    net_id_e       cap_net;
    logic          cap_slot;
    logic [TW-1:0] cap_t;

    logic [1:0]                   bank_clr;
    logic [1:0][1:0]              bank_cap;
    logic [1:0][1:0][Q-1:0]       bank_valid;
    logic [1:0][1:0][Q-1:0][TW-1:0] bank_time;

    logic [Q-1:0] fire1;
    logic [Q-1:0] fire2;
    logic [Q-1:0] out1_q;
    logic [Q-1:0] out2_q;

    // Gamma boundary detection, bank routing and replay match.
    always_comb begin
        gamma_start  = bus.grst & ~grst_q;
        // evt marks the last cycle of a gamma cycle; the swap follows it.
        evt          = gamma_start | ((state_q != WAIT_SYNC) && (counter_q == LAST));
        counter_next = evt ? '0 : counter_q + CW'(1);
        cap_bank     = sel_q ^ swap_q;
        rep_bank     = ~cap_bank;
        capture_on   = (state_q != WAIT_SYNC);
        replay_on    = (state_q == RUN) && (counter_q < SLOT_START);
        cap_net      = (counter_q >= SLOT_START) ? NET2 : NET1;
        cap_slot     = (cap_net == NET2);
        cap_t        = TW'(counter_q - (cap_slot ? SLOT_START : '0));

        bank_clr           = '0;
        bank_clr[cap_bank] = swap_q;
        bank_cap                     = '0;
        bank_cap[cap_bank][cap_slot] = capture_on;

        for (int q = 0; q < Q; q++) begin
            fire1[q] = replay_on && bank_valid[rep_bank][0][q]
                       && (bank_time[rep_bank][0][q] == TW'(counter_q));
            fire2[q] = replay_on && bank_valid[rep_bank][1][q]
                       && (bank_time[rep_bank][1][q] == TW'(counter_q));
        end
    end

    // Sync FSM, gamma counter and ping-pong pointer.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= WAIT_SYNC;
            counter_q <= '0;
            grst_q    <= 1'b0;
            swap_q    <= 1'b0;
            sel_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            grst_q <= bus.grst;
            swap_q <= evt;
            sel_q  <= cap_bank;
            case (state_q)
                WAIT_SYNC: begin
                    if (gamma_start) begin
                        state_q   <= FILL;
                        locked_q  <= 1'b1;
                        counter_q <= '0;
                    end
                end
                FILL: begin
                    counter_q <= counter_next;
                    if (evt) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    counter_q <= counter_next;
                end
                default: begin
                    state_q <= WAIT_SYNC;
                end
            endcase
        end
    end

    // Registered replay outputs.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out1_q <= '0;
            out2_q <= '0;
        end else begin
`ifdef SPIKE_HOLD_EN
            // Level-coded: hold until the gamma cycle ends, a new fire wins.
            out1_q <= fire1 | (out1_q & ~{Q{evt}});
            out2_q <= fire2 | (out2_q & ~{Q{evt}});
`else
            out1_q <= fire1;
            out2_q <= fire2;
`endif
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar s = 0; s < 2; s++) begin : g_slot
            spike_time_capture #(
                .Q (Q),
                .TW(TW)
            ) u_cap (
                .clk   (clk),
                .rstb  (rstb),
                .clear (bank_clr[b]),
                .cap_en(bank_cap[b][s]),
                .spikes(bus.col_spikes),
                .t     (cap_t),
                .valid (bank_valid[b][s]),
                .stamps(bank_time[b][s])
            );
        end
    end

    assign bus.output_spikes1 = out1_q;
    assign bus.output_spikes2 = out2_q;
    assign bus.sync_locked    = locked_q;

endmodule

// File: tb/tb_spike_demux.sv
// Bench for spike_demux: directed scenarios with literal expectations, then
// random spikes / gamma resets against a first-spike-time reference model.
module tb_spike_demux;

    localparam int Q = 2;
    localparam int G = 18;
    localparam int S = G / 2;

    logic clk  = 1'b0;
    logic rstb = 1'b0;

    always #5 clk = ~clk;

    spike_demux_if #(.Q(Q)) bus ();

    spike_demux #(
        .Q                 (Q),
        .GAMMA_CYCLE_LENGTH(G)
    ) dut (
        .clk (clk),
        .rstb(rstb),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: first-spike time per (network, line) for the gamma
    // cycle being captured and the one being replayed; -1 means no spike.
    bit           m_locked;
    bit           m_prev_grst;
    bit           m_new;
    int           m_cnt;
    int           m_gidx;
    int           cur_first[2][Q];
    int           prev_first[2][Q];
    logic [Q-1:0] exp1;
    logic [Q-1:0] exp2;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_locked    = 1'b0;
        m_prev_grst = 1'b0;
        m_new       = 1'b0;
        m_cnt       = 0;
        m_gidx      = 0;
        exp1        = '0;
        exp2        = '0;
        for (int n = 0; n < 2; n++) begin
            for (int q = 0; q < Q; q++) begin
                cur_first[n][q]  = -1;
                prev_first[n][q] = -1;
            end
        end
    endtask

    task automatic model_step();
        bit           gstart;
        bit           endg;
        int           slot;
        int           t;
        logic [Q-1:0] f1;
        logic [Q-1:0] f2;
        gstart      = bus.grst && !m_prev_grst;
        m_prev_grst = bus.grst;
        f1          = '0;
        f2          = '0;
        if (!m_locked) begin
            if (gstart) begin
                m_locked = 1'b1;
                m_cnt    = 0;
                m_new    = 1'b1;
                m_gidx   = 0;
            end
            exp1 = '0;
            exp2 = '0;
        end else begin
            if (m_new) begin
                prev_first = cur_first;
                for (int n = 0; n < 2; n++) begin
                    for (int q = 0; q < Q; q++) cur_first[n][q] = -1;
                end
                m_gidx++;
            end
            slot = (m_cnt >= S) ? 1 : 0;
            t    = m_cnt - slot * S;
            for (int q = 0; q < Q; q++) begin
                if (bus.col_spikes[q] && cur_first[slot][q] < 0) cur_first[slot][q] = t;
            end
            if (m_gidx >= 2 && m_cnt < S) begin
                for (int q = 0; q < Q; q++) begin
                    f1[q] = (prev_first[0][q] == m_cnt);
                    f2[q] = (prev_first[1][q] == m_cnt);
                end
            end
            endg = gstart || (m_cnt == G - 1);
`ifdef SPIKE_HOLD_EN
            exp1 = f1 | (endg ? '0 : exp1);
            exp2 = f2 | (endg ? '0 : exp2);
`else
            exp1 = f1;
            exp2 = f2;
`endif
            m_new = endg;
            m_cnt = endg ? 0 : m_cnt + 1;
        end
    endtask

    always @(posedge clk or negedge rstb) begin
        if (!rstb) model_reset();
        else       model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_out1", 8'(bus.output_spikes1), 8'(exp1));
        check("model_out2", 8'(bus.output_spikes2), 8'(exp2));
        check("model_lock", 8'(bus.sync_locked), 8'(m_locked));
    end

    initial begin
        logic [Q-1:0] col;
        bus.grst       = 1'b0;
        bus.col_spikes = '0;
        repeat (3) @(negedge clk);
        check("rst_out1", 8'(bus.output_spikes1), 8'h00);
        check("rst_out2", 8'(bus.output_spikes2), 8'h00);
        check("rst_lock", 8'(bus.sync_locked), 8'h00);
        rstb = 1'b1;
        repeat (50) @(negedge clk);
        check("nosync_lock", 8'(bus.sync_locked), 8'h00);
        check("nosync_out1", 8'(bus.output_spikes1), 8'h00);

        // Lock: next negedge falls in the counter-0 cycle of gamma 1.
        bus.grst = 1'b1;
        @(negedge clk);
        check("lock", 8'(bus.sync_locked), 8'h01);
        bus.grst = 1'b0;

        for (int g = 1; g <= 5; g++) begin
            for (int k = 0; k < G; k++) begin
                col = '0;
                case (g)
                    1: begin
                        if (k == 3)  col = 2'b01;
                        if (k == 12) col = 2'b10;
                    end
                    2: begin
                        if (k >= 2 && k <= 8) col = 2'b01;
                        if (k == 4) begin
                            check("basic_out1", 8'(bus.output_spikes1), 8'h01);
                            check("basic_out2", 8'(bus.output_spikes2), 8'h02);
                        end
`ifdef SPIKE_HOLD_EN
                        if (k == 17) check("hold_out1_c17", 8'(bus.output_spikes1), 8'h01);
`else
                        if (k == 3) check("basic_out1_c3", 8'(bus.output_spikes1), 8'h00);
                        if (k == 5) check("basic_out1_c5", 8'(bus.output_spikes1), 8'h00);
`endif
                    end
                    3: begin
                        if (k == 0)  col = 2'b10;
                        if (k == 17) col = 2'b01;
                        if (k == 3) begin
                            check("first_out1", 8'(bus.output_spikes1), 8'h01);
                            check("first_out2", 8'(bus.output_spikes2), 8'h00);
                        end
`ifdef SPIKE_HOLD_EN
                        if (k == 0) check("hold_out1_c0", 8'(bus.output_spikes1), 8'h00);
`else
                        if (k == 4) check("first_out1_c4", 8'(bus.output_spikes1), 8'h00);
`endif
                    end
                    4: begin
                        if (k == 5)  col = 2'b01;
                        if (k == 10) bus.grst = 1'b1;
                        if (k == 1) check("swap_edge_out1", 8'(bus.output_spikes1), 8'h02);
                        if (k == 9) check("last_slot_out2", 8'(bus.output_spikes2), 8'h01);
                    end
                    default: begin
                        if (k == 0) bus.grst = 1'b0;
                        if (k == 5) check("early_out2", 8'(bus.output_spikes2), 8'h00);
                        if (k == 6) check("early_out1", 8'(bus.output_spikes1), 8'h01);
                    end
                endcase
                bus.col_spikes = col;
                @(negedge clk);
                if (g == 4 && k == 10) break;
            end
        end

        // Random phase, with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            for (int q = 0; q < Q; q++) col[q] = ($urandom_range(0, 7) == 0);
            bus.col_spikes = col;
            if (!bus.grst) bus.grst = ($urandom_range(0, 59) == 0);
            else           bus.grst = ($urandom_range(0, 2) != 0);
            if (i == 1500) begin
                #2;
                rstb = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rstb = 1'b1;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
